// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/operand-issue stage feeding the execute ALU
//
// Decodes one MIPS-style instruction per cycle to a 4-bit ALU pattern,
// reads operands from a 32x32 register file with writeback bypass and
// holds a registered issue bundle for the ALU/writeback path.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake, instr = instruction word
//   flush               drop held bundle, block acceptance this cycle
//   wb_en/addr/data     register-file write port (also bypassed to reads)
//   out_valid/ready     issue bundle handshake
//   data_a, data_b      ALU operands; data_c = shamt field
//   alu_pattern         ALU op code
//   dest_addr, dest_en  writeback destination and enable
//   illegal             undecodable opcode/funct
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic [4:0]  data_c,
  output logic [3:0]  alu_pattern,
  output logic [4:0]  dest_addr,
  output logic        dest_en,
  output logic        illegal
);

  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // r0 is hardwired to zero; a same-cycle writeback wins over the array.
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (wb_en && wb_addr == rs) ? wb_data : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (wb_en && wb_addr == rt) ? wb_data : rf[rt];

  // Decoded bundle, plus which register (if any) each operand came from
  // so a held bundle can pick up later writebacks.
  logic [3:0]  dec_pat;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_dest;
  logic        dec_ill;
  logic [4:0]  dec_src_a, dec_src_b;
  logic        dec_src_a_en, dec_src_b_en;

  always_comb begin
    dec_pat      = 4'd0;
    dec_a        = 32'd0;
    dec_b        = 32'd0;
    dec_dest     = 5'd0;
    dec_ill      = 1'b0;
    dec_src_a    = rs;
    dec_src_b    = rt;
    dec_src_a_en = 1'b0;
    dec_src_b_en = 1'b0;
    case (op)
      6'h00: begin
        dec_a        = rs_val;
        dec_b        = rt_val;
        dec_dest     = rd;
        dec_src_a_en = 1'b1;
        dec_src_b_en = 1'b1;
        case (funct)
          6'h20, 6'h21: dec_pat = 4'd1;
          6'h22, 6'h23: dec_pat = 4'd6;
          6'h24:        dec_pat = 4'd2;
          6'h25:        dec_pat = 4'd3;
          6'h27:        dec_pat = 4'd9;
          6'h2A:        dec_pat = 4'd8;
          6'h04:        dec_pat = 4'd4;
          6'h06:        dec_pat = 4'd5;
          6'h07:        dec_pat = 4'd7;
          6'h00, 6'h02, 6'h03: begin
            // Immediate shifts: shift amount travels as operand a.
            dec_pat      = (funct == 6'h00) ? 4'd4 :
                           (funct == 6'h02) ? 4'd5 : 4'd7;
            dec_a        = {27'd0, shamt};
            dec_src_a_en = 1'b0;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A: begin
        dec_pat      = (op == 6'h0A) ? 4'd8 : 4'd1;
        dec_a        = rs_val;
        dec_b        = {{16{imm[15]}}, imm};
        dec_dest     = rt;
        dec_src_a_en = 1'b1;
      end
      6'h0C, 6'h0D: begin
        dec_pat      = (op == 6'h0C) ? 4'd2 : 4'd3;
        dec_a        = rs_val;
        dec_b        = {16'd0, imm};
        dec_dest     = rt;
        dec_src_a_en = 1'b1;
      end
      6'h0F: begin
        dec_a    = {imm, 16'd0};
        dec_dest = rt;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_pat      = 4'd0;
      dec_a        = 32'd0;
      dec_b        = 32'd0;
      dec_dest     = 5'd0;
      dec_src_a_en = 1'b0;
      dec_src_b_en = 1'b0;
    end
  end

  logic [4:0] src_a, src_b;
  logic       src_a_en, src_b_en;
  logic       accept, held, wb_live;

  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign held     = out_valid && !out_ready;
  assign wb_live  = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      out_valid   <= 1'b0;
      data_a      <= 32'd0;
      data_b      <= 32'd0;
      data_c      <= 5'd0;
      alu_pattern <= 4'd0;
      dest_addr   <= 5'd0;
      dest_en     <= 1'b0;
      illegal     <= 1'b0;
      src_a       <= 5'd0;
      src_b       <= 5'd0;
      src_a_en    <= 1'b0;
      src_b_en    <= 1'b0;
    end else begin
      if (wb_live) rf[wb_addr] <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        data_a      <= dec_a;
        data_b      <= dec_b;
        data_c      <= shamt;
        alu_pattern <= dec_pat;
        dest_addr   <= dec_dest;
        dest_en     <= !dec_ill && (dec_dest != 5'd0);
        illegal     <= dec_ill;
        src_a       <= dec_src_a;
        src_b       <= dec_src_b;
        src_a_en    <= dec_src_a_en;
        src_b_en    <= dec_src_b_en;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else if (held && wb_live) begin
        if (src_a_en && src_a == wb_addr) data_a <= wb_data;
        if (src_b_en && src_b == wb_addr) data_b <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_a, data_b;
  logic [4:0]  data_c;
  logic [3:0]  alu_pattern;
  logic [4:0]  dest_addr;
  logic        dest_en;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ADDI_R2_R1_M3 = 32'h2022FFFD;
  localparam logic [31:0] SLL_R3_R1_4   = 32'h00011900;
  localparam logic [31:0] LUI_R4        = 32'h3C041234;
  localparam logic [31:0] ADD_R5_R0_R0  = 32'h00002820;
  localparam logic [31:0] OR_R6_R1_R2   = 32'h00223025;
  localparam logic [31:0] SRAV_R7_R1_R2 = 32'h00413807;
  localparam logic [31:0] ORI_R8_R1     = 32'h34288000;
  localparam logic [31:0] ILLEGAL_OP    = 32'hFC000000;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .alu_pattern(alu_pattern), .dest_addr(dest_addr), .dest_en(dest_en),
    .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_data_a", data_a, 32'd0);
    check("rst_pattern", {28'd0, alu_pattern}, 32'd0);
    check("rst_dest_en", {31'd0, dest_en}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // r1 = 5, then addi r2,r1,-3
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    step();
    wb_en = 1'b0;
    in_valid = 1'b1; instr = ADDI_R2_R1_M3;
    step();
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_pat", {28'd0, alu_pattern}, 32'd1);
    check("addi_a", data_a, 32'd5);
    check("addi_b", data_b, 32'hFFFFFFFD);
    check("addi_c", {27'd0, data_c}, 32'd31);
    check("addi_dest", {27'd0, dest_addr}, 32'd2);
    check("addi_dest_en", {31'd0, dest_en}, 32'd1);
    check("addi_illegal", {31'd0, illegal}, 32'd0);

    // back-to-back: sll r3,r1,4 then lui r4,0x1234
    instr = SLL_R3_R1_4;
    step();
    check("sll_pat", {28'd0, alu_pattern}, 32'd4);
    check("sll_a", data_a, 32'd4);
    check("sll_b", data_b, 32'd5);
    check("sll_c", {27'd0, data_c}, 32'd4);
    check("sll_dest", {27'd0, dest_addr}, 32'd3);
    instr = LUI_R4;
    step();
    check("lui_valid", {31'd0, out_valid}, 32'd1);
    check("lui_pat", {28'd0, alu_pattern}, 32'd0);
    check("lui_a", data_a, 32'h12340000);
    check("lui_dest", {27'd0, dest_addr}, 32'd4);
    in_valid = 1'b0;
    step();
    check("pop_no_accept", {31'd0, out_valid}, 32'd0);

    // bypass: writeback r1=7 in the accept cycle
    in_valid = 1'b1; instr = ADDI_R2_R1_M3;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    step();
    in_valid = 1'b0; wb_en = 1'b0;
    check("bypass_a", data_a, 32'd7);

    // r0 write ignored, including the bypass path
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    step();
    in_valid = 1'b1; instr = ADD_R5_R0_R0;
    step();
    in_valid = 1'b0; wb_en = 1'b0;
    check("r0_a", data_a, 32'd0);
    check("r0_b", data_b, 32'd0);
    check("r0_dest", {27'd0, dest_addr}, 32'd5);
    step();

    // backpressure with operand refresh
    out_ready = 1'b0;
    in_valid = 1'b1; instr = ADDI_R2_R1_M3;
    step();
    check("hold_a_before", data_a, 32'd7);
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    instr = LUI_R4;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd9;
    step();
    check("refresh_a", data_a, 32'd9);
    check("refresh_b_kept", data_b, 32'hFFFFFFFD);
    check("refresh_pat_kept", {28'd0, alu_pattern}, 32'd1);
    check("refresh_dest_kept", {27'd0, dest_addr}, 32'd2);
    check("refresh_in_ready", {31'd0, in_ready}, 32'd0);
    // r2 is the destination, not a source: immediate must not change
    wb_addr = 5'd2; wb_data = 32'h55;
    step();
    wb_en = 1'b0;
    check("imm_not_refreshed", data_b, 32'hFFFFFFFD);
    check("held_valid", {31'd0, out_valid}, 32'd1);

    // release: or, srav, ori, illegal issue back-to-back
    out_ready = 1'b1; instr = OR_R6_R1_R2;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("or_pat", {28'd0, alu_pattern}, 32'd3);
    check("or_a", data_a, 32'd9);
    check("or_b", data_b, 32'h55);
    check("or_dest", {27'd0, dest_addr}, 32'd6);
    instr = SRAV_R7_R1_R2;
    step();
    check("srav_pat", {28'd0, alu_pattern}, 32'd7);
    check("srav_a", data_a, 32'h55);
    check("srav_b", data_b, 32'd9);
    instr = ORI_R8_R1;
    step();
    check("ori_pat", {28'd0, alu_pattern}, 32'd3);
    check("ori_b", data_b, 32'h00008000);
    check("ori_dest", {27'd0, dest_addr}, 32'd8);
    instr = ILLEGAL_OP;
    step();
    in_valid = 1'b0;
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_dest_en", {31'd0, dest_en}, 32'd0);
    check("ill_pat", {28'd0, alu_pattern}, 32'd0);
    check("ill_a", data_a, 32'd0);
    check("ill_b", data_b, 32'd0);
    step();

    // flush while holding, with an instruction presented
    out_ready = 1'b0; in_valid = 1'b1; instr = ADDI_R2_R1_M3;
    step();
    check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; out_ready = 1'b1; instr = LUI_R4;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("flush_not_consumed", {31'd0, out_valid}, 32'd0);

    // reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; instr = ADDI_R2_R1_M3;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("midrst_r1_cleared", data_a, 32'd0);
    check("midrst_reissue_valid", {31'd0, out_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/operand-issue stage sitting directly upstream of the execute ALU. It accepts one 32-bit MIPS-style instruction per cycle over a valid/ready handshake, decodes it to the ALU's 4-bit pattern code, and reads operands from an internal 32x32 register file with writeback bypass. It presents a registered `data_a`/`data_b`/`data_c`/`alu_pattern` bundle plus destination information to the ALU/writeback path over a second valid/ready handshake.

## Interface
- No parameters. Fixed 32-entry x 32-bit register file and 32-bit datapath.
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  instruction word.
- `flush`  in  1  drop the held output; block acceptance this cycle.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  5  write index.
- `wb_data`  in  32  write data.
- `out_valid`  out  1  issue bundle valid.
- `out_ready`  in  1  consumer takes the bundle.
- `data_a`, `data_b`  out  32  ALU operands.
- `data_c`  out  5  shamt field.
- `alu_pattern`  out  4  ALU op code.
- `dest_addr`  out  5  writeback register.
- `dest_en`  out  1  result is to be written.
- `illegal`  out  1  opcode/funct not decodable.

## Operation
- ALU pattern codes:
  - 0 = pass a; 1 = add; 2 = and; 3 = or.
  - 4 = b<<a[4:0]; 5 = b>>a[4:0]; 7 = b>>>a[4:0].
  - 6 = a-b; 8 = signed a<b; 9 = nor.
- R-type instructions (op 0x00): `data_a`=rs, `data_b`=rt, `dest`=rd.
  - funct 0x20/0x21 -> 1; 0x22/0x23 -> 6; 0x24 -> 2; 0x25 -> 3; 0x27 -> 9; 0x2A -> 8.
  - Variable shifts: 0x04 -> 4, 0x06 -> 5, 0x07 -> 7.
  - Immediate shifts: 0x00 -> 4, 0x02 -> 5, 0x03 -> 7, with `data_a` = zero-extended shamt.
- I-type instructions: `data_a`=rs, `dest`=rt.
  - op 0x08/0x09 -> 1, `data_b` = sign-extended imm.
  - 0x0A -> 8, `data_b` = sign-extended imm.
  - 0x0C -> 2, `data_b` = zero-extended imm.
  - 0x0D -> 3, `data_b` = zero-extended imm.
  - 0x0F (lui) -> 0, `data_a` = {imm,16'h0}.
- `data_c` = instr[10:6] for every instruction.
- `dest_en` = 1 for legal instructions with dest != 0.
- Any other op/funct: issue with `illegal`=1, pattern 0, `data_a`=`data_b`=0, `dest_en`=0.
- Register file:
  - r0 reads 0 and writes to r0 are ignored.
  - Writes commit at the clock edge when `wb_en`=1.
  - Bypass: a read whose index equals `wb_addr` (nonzero) with `wb_en`=1 in the same cycle returns `wb_data`.
- Held-operand refresh: while the bundle is held (`out_valid` && !`out_ready`), a writeback to a nonzero source register it actually uses replaces that operand at the edge. Immediate/shamt operands are never refreshed.
- `in_ready` = !`rst` && !`flush` && (!`out_valid` || `out_ready`).

## Timing
- Reset: `out_valid`, `data_a`, `data_b`, `data_c`, `alu_pattern`, `dest_addr`, `dest_en`, `illegal` all 0. All 32 registers are cleared. `in_ready` is 0 during reset and 1 the cycle after.
- Latency: the bundle appears (`out_valid`=1) the cycle after acceptance. Throughput is 1 per cycle when `out_ready` is held high.
- Hold: while `out_valid` && !`out_ready`, all outputs are stable except operand refresh.
- Simultaneous pop and accept: the new bundle replaces the old at the edge and `out_valid` stays 1.
- Pop without accept: `out_valid` goes to 0.
- Flush: next cycle `out_valid`=0. It overrides pop/accept, and the instruction presented in the flush cycle is not accepted.
- Register-file writes are never blocked by stalls or flush.
- Reset mid-stream discards the held bundle and register contents.

## Test plan
- Write r1=5. Issue 0x2022FFFD (addi r2,r1,-3). Expect next cycle: pattern 1, `data_a`=5, `data_b`=0xFFFFFFFD, `dest_addr`=2, `dest_en`=1.
- r1=5. Issue 0x00011900 (sll r3,r1,4). Expect pattern 4, `data_a`=4, `data_b`=5, `data_c`=4. Issue 0x3C041234 (lui). Expect pattern 0, `data_a`=0x12340000, `dest_addr`=4.
- Bypass: in the same cycle as accepting addi r2,r1,-3, drive `wb_en`=1, `wb_addr`=1, `wb_data`=7. Expect `data_a`=7. A write to r0 then a read of r0 gives 0.
- Backpressure: hold `out_ready`=0 with addi r2,r1,-3 held, then write r1=9. Expect `data_a`=9 next cycle with other fields unchanged and `in_ready`=0. Release `out_ready` and the next instruction issues back-to-back.
- Illegal 0xFC000000: expect `illegal`=1, `dest_en`=0, pattern 0, `data_a`=`data_b`=0.
- Flush while holding a bundle with `in_valid`=1: next cycle `out_valid`=0 and the presented instruction is not consumed. Assert `rst` mid-stream: `out_valid`=0 and a subsequent read of r1 returns 0.
